// File: rtl/sub_shift_stage_if.sv
// Block handshake bundle for the SubBytes+ShiftRows stage.
// slave = the stage itself, master = upstream/downstream environment.
interface sub_shift_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         last_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         last_out;

    modport slave (
        input  in_valid,
        input  state_in,
        input  last_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output last_out
    );

    modport master (
        output in_valid,
        output state_in,
        output last_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  last_out
    );
endinterface

// File: rtl/sub_shift_stage.sv
// Registered AES SubBytes + ShiftRows stage, column-serial through four shared S-boxes.
// Define SUB_SHIFT_FULL_EN to substitute the whole state in a single SUB cycle (16 S-boxes).
module sub_shift_stage (
    input  logic              clk,
    input  logic              rst_n,
    sub_shift_stage_if.slave  bus_io
);

    // state | meaning
    // IDLE  | empty, ready for a block
    // SUB   | substituting the working register
    // HOLD  | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // work_q[3-c][3-r] is byte (row r, col c), i.e. bits [127-8*(4c+r) -: 8]
    state_e                 state_q;
    logic [3:0][3:0][7:0]   work_q;
    logic                   last_q;
    logic                   out_valid_q;
    logic [3:0][3:0][7:0]   shifted;
    logic                   accept;

`ifdef SUB_SHIFT_FULL_EN
    logic [3:0][3:0][7:0]   sub_all_d;

    for (genvar c = 0; c < 4; c++) begin : g_sbox_col
        for (genvar r = 0; r < 4; r++) begin : g_sbox_row
            assign sub_all_d[c][r] = SBOX[work_q[c][r]];
        end
    end
`else
    logic [1:0]             col_cnt_q;
    logic [1:0]             col_idx;
    logic [3:0][7:0]        sub_col_d;

    assign col_idx = 2'd3 - col_cnt_q;

    for (genvar r = 0; r < 4; r++) begin : g_sbox
        assign sub_col_d[r] = SBOX[work_q[col_idx][r]];
    end
`endif

    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign shifted[3-c][3-r] = work_q[3-((c+r)%4)][3-r];
        end
    end

    assign bus_io.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus_io.out_ready);
    assign accept           = bus_io.in_valid && bus_io.in_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.state_out = shifted;
    assign bus_io.last_out  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifndef SUB_SHIFT_FULL_EN
            col_cnt_q   <= 2'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        work_q  <= bus_io.state_in;
                        last_q  <= bus_io.last_in;
                        state_q <= ST_SUB;
`ifndef SUB_SHIFT_FULL_EN
                        col_cnt_q <= 2'd0;
`endif
                    end
                end
                ST_SUB: begin
`ifdef SUB_SHIFT_FULL_EN
                    work_q      <= sub_all_d;
                    state_q     <= ST_HOLD;
                    out_valid_q <= 1'b1;
`else
                    work_q[col_idx] <= sub_col_d;
                    col_cnt_q       <= col_cnt_q + 2'd1;
                    if (col_cnt_q == 2'd3) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        // back-to-back: next block is taken on the same edge as the transfer
                        if (bus_io.in_valid) begin
                            work_q  <= bus_io.state_in;
                            last_q  <= bus_io.last_in;
                            state_q <= ST_SUB;
`ifndef SUB_SHIFT_FULL_EN
                            col_cnt_q <= 2'd0;
`endif
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_shift_stage.sv
// Directed bench for sub_shift_stage: FIPS-197 vectors, backpressure, back-to-back and reset cases.
// Honours SUB_SHIFT_FULL_EN for the expected latency.
module tb_sub_shift_stage;

`ifdef SUB_SHIFT_FULL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif
    localparam int BOUND = 20;

    localparam logic [127:0] APPB_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ZERO_OUT  = {16{8'h63}};
    localparam logic [127:0] COL_IN    = 128'h00000000_00000000_00000000_53535353;
    localparam logic [127:0] COL_OUT   = 128'h636363ed_6363ed63_63ed6363_ed636363;
    localparam logic [127:0] JUNK      = 128'hdeadbeef_01234567_89abcdef_f00dcafe;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   lat;
    bit   ok;

    sub_shift_stage_if bus ();

    sub_shift_stage u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [127:0] blk, input logic lst);
        bus.state_in = blk;
        bus.last_in  = lst;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // counts edges after the accept edge until out_valid; toggles junk on in_valid during SUB if asked
    task automatic wait_out(input bit toggle, output int l);
        l = 0;
        for (int n = 1; n <= BOUND; n++) begin
            if (toggle) begin
                bus.state_in = JUNK;
                bus.in_valid = (n < LAT) && (n % 2 == 1);
            end
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                l = n;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.state_in  = '0;
        bus.last_in   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
        chk("rst_state_out", bus.state_out,       128'h0);
        chk("rst_last_out",  128'(bus.last_out),  128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // App. B round 1, then backpressure with a pending block
        bus.out_ready = 1'b0;
        send(APPB_IN, 1'b0);
        chk("sub_in_ready", 128'(bus.in_ready), 128'(0));
        wait_out(1'b0, lat);
        chk("appb_latency", 128'(lat),           128'(LAT));
        chk("appb_state",   bus.state_out,       APPB_OUT);
        chk("appb_last",    128'(bus.last_out),  128'(0));

        bus.state_in = '0;
        bus.last_in  = 1'b1;
        bus.in_valid = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            ok &= bus.out_valid && (bus.state_out == APPB_OUT) && !bus.last_out && !bus.in_ready;
        end
        chk("hold_stable", 128'(ok), 128'(1));
        bus.out_ready = 1'b1;
        #1;
        chk("hold_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("b2b_out_valid", 128'(bus.out_valid), 128'(0));
        chk("b2b_in_ready",  128'(bus.in_ready),  128'(0));
        wait_out(1'b0, lat);
        chk("zero_latency", 128'(lat),          128'(LAT));
        chk("zero_state",   bus.state_out,      ZERO_OUT);
        chk("zero_last",    128'(bus.last_out), 128'(1));

        // column isolation with in_valid toggling during SUB
        send(COL_IN, 1'b0);
        wait_out(1'b1, lat);
        chk("col_latency", 128'(lat),          128'(LAT));
        chk("col_state",   bus.state_out,      COL_OUT);
        chk("col_last",    128'(bus.last_out), 128'(0));
        @(posedge clk);
        #1;
        chk("drop_out_valid", 128'(bus.out_valid), 128'(0));
        chk("idle_in_ready",  128'(bus.in_ready),  128'(1));

        // reset in the middle of SUB discards the block
        send(APPB_IN, 1'b1);
        if (LAT > 1) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst_in_ready",  128'(bus.in_ready),  128'(1));
        chk("midrst_state_out", bus.state_out,       128'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(COL_IN, 1'b1);
        wait_out(1'b0, lat);
        chk("post_rst_latency", 128'(lat),          128'(LAT));
        chk("post_rst_state",   bus.state_out,      COL_OUT);
        chk("post_rst_last",    128'(bus.last_out), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_shift_stage.md
# sub_shift_stage

Registered SubBytes + ShiftRows stage of the AES encryption round datapath. It sits directly upstream of `mixColumns` and feeds it a 128-bit state whose column slicing matches `mixColumns`. It substitutes one 32-bit column per cycle through four shared S-boxes, then presents the row-shifted result behind a valid/ready handshake. A `last` tag travels with each block so downstream logic can bypass MixColumns in the final round.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — `state_in` and `last_in` are valid.
- `in_ready` output 1 — stage can accept a block.
- `state_in` input 128 — round-input state.
- `last_in` input 1 — block is in the final round.
- `out_valid` output 1 — `state_out` and `last_out` are valid.
- `out_ready` input 1 — downstream accepts the block.
- `state_out` output 128 — ShiftRows(SubBytes(`state_in`)).
- `last_out` output 1 — registered copy of `last_in`.

## Operation
Byte layout:
- Byte (row r, col c) is at bits [127-8*(4c+r) -: 8].
- Column c is at [127-32c -: 32].

S-box:
- FIPS-197 forward S-box.
- Four instances, shared across columns.
- Implemented either as a table or as a GF(2^8) inverse plus affine transform.

ShiftRows:
- out(r,c) = sub(r,(c+r) mod 4).
- Purely combinational on the working register; no extra cycle.

FSM states:
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`: capture `state_in` into the working register, capture `last_in`, clear `col_cnt` to 0, go to SUB.
- SUB:
  - Each cycle, replace column `col_cnt` of the working register with its S-box result, then increment `col_cnt`.
  - After the column 3 update, go to HOLD.
  - `in_ready` = 0.
- HOLD:
  - `out_valid` = 1; `state_out`/`last_out` are stable.
  - On `out_ready`, the block is transferred.
  - If `in_valid` is also high in the same cycle, capture the new block and go to SUB (back-to-back). Otherwise go to IDLE.
  - `in_ready` = `out_ready`.

Boundary conditions:
- `out_ready` low in HOLD: hold indefinitely; outputs do not change.
- `in_valid` toggling while in SUB: ignored; `in_ready` is 0.
- `col_cnt` is 2 bits and only counts in SUB; its wrap from 3 to 0 coincides with the SUB→HOLD transition.
- Reset asserted mid-operation: immediately go to IDLE. Any partial block is discarded with no output.

Reset values:
- FSM = IDLE.
- `in_ready` = 1 (combinational from IDLE).
- `out_valid` = 0.
- Working register = 128'h0, so `state_out` = 128'h0.
- `last_out` = 0.
- `col_cnt` = 0.

## Timing
- Accept on edge E0 (`in_valid` && `in_ready`).
- Columns 0..3 are substituted on edges E1..E4.
- `out_valid` is high from after E4.
- Latency: 4 cycles from accept to `out_valid`.
- Peak throughput: one block per 5 cycles, with HOLD→SUB back-to-back acceptance on the output-handshake edge.
- `in_ready` depends combinationally on `out_ready` only in HOLD. `out_valid` and `state_out` are register-driven.

## Configuration
- `SUB_SHIFT_FULL_EN` defined:
  - 16 S-box instances.
  - SUB lasts exactly one cycle and substitutes all four columns at once.
  - Latency is 1 cycle; peak throughput is one block per 2 cycles.
  - `col_cnt` is not implemented.
- `SUB_SHIFT_FULL_EN` undefined: four shared S-boxes, 4-cycle SUB as described above.
- Handshake, FSM states, reset values and output function are identical in both builds.

## Test plan
- Reset: assert `rst_n`=0 mid-SUB → `out_valid`=0, `in_ready`=1, `state_out`=0. After release, the next block completes normally with 4-cycle latency.
- FIPS-197 App. B round 1: `state_in`=193de3bea0f4e22b9ac68d2ae9f84808, `last_in`=0 → after 4 cycles `out_valid`=1, `state_out`=d4bf5d30e0b452aeb84111f11e2798e5, `last_out`=0.
- All-zero block: `state_in`=0, `last_in`=1 → `state_out`=6363...63 (16 bytes of 63), `last_out`=1.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → output stable, `in_ready`=0, new `in_valid` ignored. Raise `out_ready` with `in_valid` high → the new block is accepted on the same edge and its output appears 4 cycles later.
- Column isolation: `state_in`=00000000_00000000_00000000_53535353 → `state_out` bytes follow the ShiftRows mapping: row r of column (3-r) mod 4 = ed, all other bytes 63.
- `SUB_SHIFT_FULL_EN` build: rerun the App. B vector → identical `state_out`, with `out_valid` 1 cycle after accept.
